// File: rtl/time_load_conditioner.sv
// time_load_conditioner: synchronise and debounce the load key, then validate and strobe the BCD switch time
module time_load_conditioner #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 19
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        key_n_i,
  input  logic [15:0] sw_i,
  output logic        load_o,
  output logic        load_err_o,
  output logic [3:0]  hr_hi_o,
  output logic [3:0]  hr_lo_o,
  output logic [3:0]  min_hi_o,
  output logic [3:0]  min_lo_o
);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;
  logic             r_key_s1, r_key_s2;
  logic [15:0]      r_sw_s1, r_sw_s2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_cap, w_valid, w_done;
  logic             r_load, r_err;
  logic [15:0]      r_digits;
  // two-flop synchronisers; the key idles released so reset never looks like a press
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_key_s1 <= 1'b1;
      r_key_s2 <= 1'b1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= key_n_i;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= sw_i;
      r_sw_s2  <= r_sw_s1;
    end
  end
  assign w_done  = r_cnt == CNT_W'(DB_CYCLES - 1);
  assign w_valid = (r_sw_s2[15:12] <= 4'd2) && (r_sw_s2[11:8] <= 4'd9) &&
                   !(r_sw_s2[15:12] == 4'd2 && r_sw_s2[11:8] > 4'd3) &&
                   (r_sw_s2[7:4] <= 4'd5) && (r_sw_s2[3:0] <= 4'd9);
  // state and debounce counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // next state; the counter clears on every transition and only counts while debouncing
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_cap       = 1'b0;
    case (r_state)
      IDLE:        w_state_nxt = r_key_s2 ? IDLE : DEB_PRESS;
      DEB_PRESS: begin
        if (r_key_s2) w_state_nxt = IDLE;
        else if (w_done) begin
          w_cap       = 1'b1;
          w_state_nxt = PRESSED;
        end else w_cnt_nxt = r_cnt + 1'b1;
      end
      PRESSED:     w_state_nxt = r_key_s2 ? DEB_RELEASE : PRESSED;
      DEB_RELEASE: begin
        if (!r_key_s2) w_state_nxt = PRESSED;
        else if (w_done) w_state_nxt = IDLE;
        else w_cnt_nxt = r_cnt + 1'b1;
      end
      default:     w_state_nxt = IDLE;
    endcase
  end
  // strobes and digits update on the capture edge; invalid values leave the digits untouched
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_load   <= 1'b0;
      r_err    <= 1'b0;
      r_digits <= '0;
    end else begin
      r_load <= w_cap && w_valid;
      r_err  <= w_cap && !w_valid;
      if (w_cap && w_valid) r_digits <= r_sw_s2;
    end
  end
  assign load_o     = r_load;
  assign load_err_o = r_err;
  assign hr_hi_o    = r_digits[15:12];
  assign hr_lo_o    = r_digits[11:8];
  assign min_hi_o   = r_digits[7:4];
  assign min_lo_o   = r_digits[3:0];
endmodule

// File: tb/tb_time_load_conditioner.sv
// tb_time_load_conditioner: directed checks of debounce, validation, strobes and reset
module tb_time_load_conditioner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_n = 1'b1;
  logic [15:0] sw = '0;
  logic        load, load_err;
  logic [3:0]  hr_hi, hr_lo, min_hi, min_lo;
  int          n_chk = 0, n_pass = 0;
  int          n_load = 0, n_err = 0, n_both = 0;
  int          l0, e0;
  time_load_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .key_n_i(key_n), .sw_i(sw),
    .load_o(load), .load_err_o(load_err),
    .hr_hi_o(hr_hi), .hr_lo_o(hr_lo), .min_hi_o(min_hi), .min_lo_o(min_lo)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (load) n_load++;
    if (load_err) n_err++;
    if (load && load_err) n_both++;
  end
  wire [15:0] digits = {hr_hi, hr_lo, min_hi, min_lo};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [15:0] v, input int hold);
    sw = v;
    repeat (3) tick();
    key_n = 1'b0;
    repeat (hold) tick();
    key_n = 1'b1;
    repeat (12) tick();
  endtask
  task automatic latency(input string tag, input logic [15:0] exp);
    repeat (6) tick();
    chk({tag, "_load_e6"}, load, 1'b0);
    tick();
    chk({tag, "_load_e7"}, load, 1'b1);
    chk({tag, "_err_e7"}, load_err, 1'b0);
    chk({tag, "_digits"}, digits, exp);
    tick();
    chk({tag, "_load_e8"}, load, 1'b0);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_outputs", {load, load_err, digits}, 18'h0);
    rst_n = 1'b1;
    tick();
    sw = 16'h1234;
    repeat (3) tick();
    l0 = n_load; e0 = n_err;
    key_n = 1'b0;
    latency("t1", 16'h1234);
    repeat (12) tick();
    key_n = 1'b1;
    repeat (12) tick();
    chk("t1_nload", n_load - l0, 1);
    chk("t1_nerr", n_err - e0, 0);
    l0 = n_load; e0 = n_err;
    sw = 16'h2222;
    repeat (2) begin
      key_n = 1'b0;
      repeat (3) tick();
      key_n = 1'b1;
      repeat (3) tick();
    end
    repeat (10) tick();
    chk("t2_nload", n_load - l0, 0);
    chk("t2_nerr", n_err - e0, 0);
    chk("t2_digits", digits, 16'h1234);
    l0 = n_load; e0 = n_err;
    press(16'h2400, 20);
    chk("t3a_nerr", n_err - e0, 1);
    chk("t3a_nload", n_load - l0, 0);
    chk("t3a_digits", digits, 16'h1234);
    press(16'h2359, 20);
    chk("t3b_nload", n_load - l0, 1);
    chk("t3b_digits", digits, 16'h2359);
    press(16'h1260, 20);
    chk("t3c_nerr", n_err - e0, 2);
    chk("t3c_digits", digits, 16'h2359);
    l0 = n_load;
    sw = 16'h1111;
    repeat (3) tick();
    key_n = 1'b0;
    repeat (100) tick();
    repeat (2) begin
      key_n = 1'b1;
      repeat (2) tick();
      key_n = 1'b0;
      repeat (2) tick();
    end
    key_n = 1'b1;
    repeat (12) tick();
    chk("t4_nload_one", n_load - l0, 1);
    chk("t4_digits", digits, 16'h1111);
    press(16'h0123, 10);
    chk("t4_nload_two", n_load - l0, 2);
    chk("t4_digits2", digits, 16'h0123);
    l0 = n_load; e0 = n_err;
    sw = 16'h0547;
    repeat (3) tick();
    key_n = 1'b0;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1 chk("t5_async_rst", {load, load_err, digits}, 18'h0);
    repeat (2) tick();
    chk("t5_nload_rst", n_load - l0, 0);
    chk("t5_nerr_rst", n_err - e0, 0);
    rst_n = 1'b1;
    latency("t5", 16'h0547);
    key_n = 1'b1;
    repeat (12) tick();
    l0 = n_load;
    sw = 16'h0830;
    repeat (3) tick();
    key_n = 1'b0;
    repeat (12) tick();
    chk("t6_loaded", digits, 16'h0830);
    sw = 16'h0945;
    repeat (10) tick();
    chk("t6_pressed_hold", digits, 16'h0830);
    key_n = 1'b1;
    repeat (3) tick();
    sw = 16'h0100;
    repeat (3) tick();
    sw = 16'h0945;
    repeat (10) tick();
    chk("t6_release_hold", digits, 16'h0830);
    chk("t6_nload", n_load - l0, 1);
    press(16'h0945, 10);
    chk("t6_reload", digits, 16'h0945);
    chk("t6_nload2", n_load - l0, 2);
    chk("never_both", n_both, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
